// File: rtl/four_port_pkg.sv
// four_port_pkg
// Shared definitions for the four-port word-line decoder.
//   state_t  : decoder FSM states (IDLE, COLLECT, OUT)
//   N_PORTS  : default number of word-line ports
//   CNT_W    : width of the accepted-code counter (0..4)
//   TMO_W    : width of the COLLECT idle-timeout counter
//   CNT_MAX  : saturation value of the accepted-code counter
package four_port_pkg;

  localparam int N_PORTS = 4;
  localparam int CNT_W   = 3;
  localparam int TMO_W   = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } state_t;

endpackage

// File: rtl/four_port_decoder_onehot_check.sv
// onehot_check
// Combinational code checker for the word-line decoder. Only instantiated
// when FOUR_PORT_DECODER_CHECK_EN is defined.
// Ports:
//   code       in  N  incoming word-line code
//   vec        in  N  vector merged so far in the current frame
//   is_onehot  out 1  code has exactly one bit set
//   is_dup     out 1  code shares a bit with vec (port already seen)
module onehot_check #(
  parameter int N = 4
) (
  input  logic [N-1:0] code,
  input  logic [N-1:0] vec,
  output logic         is_onehot,
  output logic         is_dup
);

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
  assign is_onehot = (code != '0) && ((code & (code - 1'b1)) == '0);
  assign is_dup    = |(code & vec);

endmodule

// File: rtl/four_port_decoder.sv
// four_port_decoder
// Receive side of the four-port one-hot encoder link. Merges the serial
// stream of one-hot word-line codes back into the request vector and
// presents it with a one-cycle valid pulse when the encoder signals done.
//
// Configuration: define FOUR_PORT_DECODER_CHECK_EN to build in the code
// checker (multi-bit and duplicate-port codes are rejected and flag err_o).
// Without it every nonzero code is merged and err_o is tied to 0.
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        synchronous active-high reset
//   wl_i         in   N_PORTS  incoming one-hot code
//   valid_i      in   1        wl_i qualifier
//   done_i       in   1        end-of-frame level from the encoder
//   wl_vec_o     out  N_PORTS  reconstructed request vector
//   vec_valid_o  out  1        one-cycle pulse: wl_vec_o holds a completed frame
//   count_o      out  3        codes accepted in the current or last frame
//   busy_o       out  1        high while collecting a frame
//   err_o        out  1        sticky frame error (checker build only)
//   state_dbg    out  2        current FSM state (state_t encoding)
//
// Handshake: there is no backpressure. A code is taken on any rising edge
// where valid_i is high and wl_i is nonzero; valid_i with wl_i == 0 carries
// nothing. done_i is a level sampled only while collecting; a code and
// done_i on the same edge close the frame with that code included.
module four_port_decoder
  import four_port_pkg::*;
#(
  parameter int N_PORTS = four_port_pkg::N_PORTS,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] wl_i,
  input  logic               valid_i,
  input  logic               done_i,
  output logic [N_PORTS-1:0] wl_vec_o,
  output logic               vec_valid_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [1:0]         state_dbg
);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;

  logic accept_code;
  logic good_code;
  logic frame_start;
  logic tmo_abort;

  assign state_dbg = state;

  always_comb begin
    accept_code = 1'b0;
    frame_start = 1'b0;
    tmo_abort   = 1'b0;
    accept_code = valid_i && (wl_i != '0);
    frame_start = (state == IDLE) && accept_code;
    // The abort fires on the idle cycle that would take the counter to TIMEOUT.
    tmo_abort   = (state == COLLECT) && !done_i && !valid_i &&
                  (tmo_cnt == TMO_W'(TIMEOUT - 1));
  end

`ifdef FOUR_PORT_DECODER_CHECK_EN
  logic [N_PORTS-1:0] chk_vec;
  logic               is_onehot;
  logic               is_dup;
  logic               bad_code;

  // The first code of a frame is checked against an empty vector, since the
  // previous frame's vector is about to be discarded.
  assign chk_vec = (state == IDLE) ? '0 : wl_vec_o;

  onehot_check #(
    .N (N_PORTS)
  ) u_onehot_check (
    .code      (wl_i),
    .vec       (chk_vec),
    .is_onehot (is_onehot),
    .is_dup    (is_dup)
  );

  assign good_code = is_onehot && !is_dup;
  assign bad_code  = accept_code && !good_code && (state != OUT);

  // Set wins over the frame-start clear so a bad first code is still flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (bad_code || tmo_abort) begin
      err_o <= 1'b1;
    end else if (frame_start) begin
      err_o <= 1'b0;
    end
  end
`else
  assign good_code = 1'b1;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wl_vec_o    <= '0;
      vec_valid_o <= 1'b0;
      count_o     <= '0;
      busy_o      <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          vec_valid_o <= 1'b0;
          if (frame_start) begin
            state   <= COLLECT;
            busy_o  <= 1'b1;
            tmo_cnt <= '0;
            if (good_code) begin
              wl_vec_o <= wl_i;
              count_o  <= CNT_W'(1);
            end else begin
              wl_vec_o <= '0;
              count_o  <= '0;
            end
          end
        end

        COLLECT: begin
          if (accept_code) begin
            tmo_cnt <= '0;
            if (good_code) begin
              wl_vec_o <= wl_vec_o | wl_i;
              if (count_o != CNT_MAX) begin
                count_o <= count_o + CNT_W'(1);
              end
            end
          end
          if (done_i) begin
            state       <= OUT;
            busy_o      <= 1'b0;
            vec_valid_o <= 1'b1;
          end else if (tmo_abort) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            wl_vec_o <= '0;
            tmo_cnt  <= '0;
          end else if (!valid_i) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        OUT: begin
          // Codes arriving here are dropped; the encoder never sends one.
          vec_valid_o <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          vec_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_port_decoder.sv
// tb_four_port_decoder
// Directed self-checking bench for four_port_decoder. Expected values are
// hand-computed; those that depend on FOUR_PORT_DECODER_CHECK_EN select
// between the two builds.
module tb_four_port_decoder;

`ifdef FOUR_PORT_DECODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_OUT     = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] wl_i;
  logic       valid_i;
  logic       done_i;
  logic [3:0] wl_vec_o;
  logic       vec_valid_o;
  logic [2:0] count_o;
  logic       busy_o;
  logic       err_o;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  four_port_decoder #(
    .N_PORTS (4),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wl_i        (wl_i),
    .valid_i     (valid_i),
    .done_i      (done_i),
    .wl_vec_o    (wl_vec_o),
    .vec_valid_o (vec_valid_o),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs, then let one rising edge sample them; outputs are read 1ns
  // after the edge.
  task automatic drive(input logic v, input logic [3:0] code, input logic d);
    valid_i = v;
    wl_i    = code;
    done_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 1'b0);
  endtask

  // Close a frame with done_i (optionally carrying a final code) and check
  // the single valid pulse and the held result.
  task automatic close_frame(input string tag, input logic v, input logic [3:0] code,
                             input logic [3:0] exp_vec, input logic [2:0] exp_cnt);
    exp_q.push_back(exp_vec);
    drive(v, code, 1'b1);
    check({tag, "_pulse"}, 8'(vec_valid_o), 8'd1);
    check({tag, "_vec"}, 8'(wl_vec_o), 8'(exp_q.pop_front()));
    check({tag, "_cnt"}, 8'(count_o), 8'(exp_cnt));
    check({tag, "_busy"}, 8'(busy_o), 8'd0);
    idle();
    check({tag, "_pulse_end"}, 8'(vec_valid_o), 8'd0);
    check({tag, "_hold_vec"}, 8'(wl_vec_o), 8'(exp_vec));
    check({tag, "_state"}, 8'(state_dbg), 8'(S_IDLE));
  endtask

  initial begin
    bit seen_pulse;

    rst = 1'b1;
    valid_i = 1'b0;
    wl_i = 4'b0000;
    done_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_vec", 8'(wl_vec_o), 8'd0);
    check("rst_valid", 8'(vec_valid_o), 8'd0);
    check("rst_cnt", 8'(count_o), 8'd0);
    check("rst_busy", 8'(busy_o), 8'd0);
    check("rst_err", 8'(err_o), 8'd0);
    check("rst_state", 8'(state_dbg), 8'(S_IDLE));
    rst = 1'b0;

    // Three codes then done on the next cycle.
    drive(1'b1, 4'b0001, 1'b0);
    check("f1_busy", 8'(busy_o), 8'd1);
    check("f1_cnt1", 8'(count_o), 8'd1);
    check("f1_state", 8'(state_dbg), 8'(S_COLLECT));
    drive(1'b1, 4'b0100, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    check("f1_vec_mid", 8'(wl_vec_o), 8'b1101);
    check("f1_no_pulse", 8'(vec_valid_o), 8'd0);
    close_frame("f1", 1'b0, 4'b0000, 4'b1101, 3'd3);

    // Code and done in the same cycle: code is included.
    drive(1'b1, 4'b0001, 1'b0);
    close_frame("f2", 1'b1, 4'b0010, 4'b0011, 3'd2);

    // Timeout: one code, then 15 idle cycles.
    drive(1'b1, 4'b0001, 1'b0);
    check("to_vec0", 8'(wl_vec_o), 8'b0001);
    seen_pulse = 1'b0;
    for (int i = 0; i < 14; i++) begin
      idle();
      if (vec_valid_o) seen_pulse = 1'b1;
    end
    check("to_busy_14", 8'(busy_o), 8'd1);
    idle();
    if (vec_valid_o) seen_pulse = 1'b1;
    check("to_no_pulse", 8'(seen_pulse), 8'd0);
    check("to_busy", 8'(busy_o), 8'd0);
    check("to_state", 8'(state_dbg), 8'(S_IDLE));
    check("to_vec", 8'(wl_vec_o), 8'd0);
    check("to_err", 8'(err_o), 8'(CHK));

    // IDLE ignores done alone and valid with a zero code.
    drive(1'b0, 4'b0000, 1'b1);
    check("idle_done_valid", 8'(vec_valid_o), 8'd0);
    check("idle_done_state", 8'(state_dbg), 8'(S_IDLE));
    drive(1'b1, 4'b0000, 1'b0);
    check("idle_zero_busy", 8'(busy_o), 8'd0);

    // Multi-bit and duplicate codes.
    drive(1'b1, 4'b0100, 1'b0);
    check("chk_err_clr", 8'(err_o), 8'd0);
    drive(1'b1, 4'b0110, 1'b0);
    check("chk_err_set", 8'(err_o), 8'(CHK));
    drive(1'b1, 4'b0100, 1'b0);
    close_frame("chk", 1'b0, 4'b0000, CHK ? 4'b0100 : 4'b0110, CHK ? 3'd1 : 3'd3);
    check("chk_err_hold", 8'(err_o), 8'(CHK));

    // Count saturates at 4 (fifth code is a repeat).
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0100, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    check("sat_cnt4", 8'(count_o), 8'd4);
    drive(1'b1, 4'b0001, 1'b0);
    close_frame("sat", 1'b0, 4'b0000, 4'b1111, 3'd4);

    // Reset mid-frame.
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0010, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("mrst_vec", 8'(wl_vec_o), 8'd0);
    check("mrst_cnt", 8'(count_o), 8'd0);
    check("mrst_busy", 8'(busy_o), 8'd0);
    check("mrst_state", 8'(state_dbg), 8'(S_IDLE));
    drive(1'b1, 4'b1000, 1'b0);
    close_frame("mrst_f", 1'b0, 4'b0000, 4'b1000, 3'd1);

    // Back-to-back frames; a duplicate in the first raises err (checker build).
    drive(1'b1, 4'b0001, 1'b0);
    exp_q.push_back(4'b0001);
    drive(1'b1, 4'b0001, 1'b1);
    check("bb1_pulse", 8'(vec_valid_o), 8'd1);
    check("bb1_vec", 8'(wl_vec_o), 8'(exp_q.pop_front()));
    check("bb1_cnt", 8'(count_o), CHK ? 8'd1 : 8'd2);
    check("bb1_err", 8'(err_o), 8'(CHK));
    // A code presented during OUT is dropped.
    drive(1'b1, 4'b0010, 1'b0);
    check("bb_out_drop_vec", 8'(wl_vec_o), 8'b0001);
    check("bb_out_drop_busy", 8'(busy_o), 8'd0);
    check("bb_out_pulse_end", 8'(vec_valid_o), 8'd0);
    drive(1'b1, 4'b0010, 1'b0);
    check("bb2_err_clr", 8'(err_o), 8'd0);
    check("bb2_cnt1", 8'(count_o), 8'd1);
    close_frame("bb2", 1'b0, 4'b0000, 4'b0010, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
